// File: rtl/ret_addr_stack_pkg.sv
// Shared definitions for the fetch-stage return address stack.
//   cvw_t      : core configuration record (only XLEN is used here)
//   CVW_RV32   : a 32-bit configuration
//   CALL/RETURN/JUMP/BRANCH : bit indices in the 4-bit instruction class,
//                             shared with the BTB and the predictor top.
package ret_addr_stack_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t CVW_RV32 = '{XLEN: 32};

  localparam int CALL   = 3;
  localparam int RETURN = 2;
  localparam int JUMP   = 1;
  localparam int BRANCH = 0;

endpackage

// File: rtl/ras_ptr.sv
// Modulo up/down stack pointer.
//   clk, reset  : clock, synchronous active-low reset (ptr -> 0)
//   load        : take load_val (wins over inc/dec)
//   load_val    : value to load
//   inc, dec    : step up/down; both together leave the pointer unchanged
//   ptr         : registered pointer
//   ptr_next    : value ptr takes at the next edge (ignoring reset)
module ras_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] ptr,
  output logic [PW-1:0] ptr_next
);

  // Wraps naturally at PW bits, so overflow/underflow need no special case.
  always_comb begin
    ptr_next = ptr;
    if (load) ptr_next = load_val;
    else      ptr_next = ptr + PW'(inc) - PW'(dec);
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr <= '0;
    else        ptr <= ptr_next;
  end

endmodule

// File: rtl/ret_addr_stack.sv
// Return address stack for the fetch-stage branch predictor.
//   clk, reset      : clock, synchronous active-low reset
//   StallF, StallE  : Fetch / Execute stalls
//   FlushD, FlushM  : Decode / Memory flushes
//   BTBIClassF      : predicted class in Fetch ([3] call [2] return [1] jump [0] branch)
//   InstrClassE     : decoded class in Execute, same encoding
//   PCLinkE         : link address of the Execute instruction
//   RASPCF          : predicted return target, mem[spec_ptr] (combinational)
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter cvw_t P       = CVW_RV32,
  parameter int   ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallF,
  input  logic                  StallE,
  input  logic                  FlushD,
  input  logic                  FlushM,
  input  logic [3:0]            BTBIClassF,
  input  logic [3:0]            InstrClassE,
  input  logic [P.XLEN-1:0]     PCLinkE,
  output logic [P.XLEN-1:0]     RASPCF
);

  localparam int XLEN = P.XLEN;
  localparam int PW   = $clog2(ENTRIES);

  logic            pop_f, adv_e, push_e, ret_e;
  logic [PW-1:0]   spec_ptr, commit_ptr, commit_next, wr_addr;
  logic [PW-1:0]   unused_spec_next;
  logic            unused_class;
  logic [XLEN-1:0] mem [ENTRIES];

  assign pop_f  = BTBIClassF[RETURN] & ~StallF;
  assign adv_e  = ~StallE & ~FlushM;
  assign push_e = InstrClassE[CALL] & adv_e;
  assign ret_e  = InstrClassE[RETURN] & adv_e;

  assign unused_class = ^{BTBIClassF[CALL], BTBIClassF[JUMP], BTBIClassF[BRANCH],
                          InstrClassE[JUMP], InstrClassE[BRANCH]};

  // A call+return (coroutine) is pop-then-push: the pointer nets to zero
  // and the link overwrites the current committed top.
  ras_ptr #(.PW(PW)) u_commit_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (push_e & ~ret_e),
    .dec      (ret_e & ~push_e),
    .ptr      (commit_ptr),
    .ptr_next (commit_next)
  );

  // Returns in Execute do not move the speculative pointer: a correct
  // prediction already popped in Fetch, a wrong one comes with FlushD.
  ras_ptr #(.PW(PW)) u_spec_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (FlushD),
    .load_val (commit_next),
    .inc      (push_e),
    .dec      (pop_f),
    .ptr      (spec_ptr),
    .ptr_next (unused_spec_next)
  );

  assign wr_addr = ret_e ? commit_ptr : commit_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (push_e) begin
      mem[wr_addr] <= PCLinkE;
    end
  end

  assign RASPCF = mem[spec_ptr];

endmodule

// File: tb/tb_ret_addr_stack.sv
module tb_ret_addr_stack;
  import ret_addr_stack_pkg::*;

  localparam cvw_t TB_CFG = '{XLEN: 32};

  logic        clk = 1'b0;
  logic        reset, StallF, StallE, FlushD, FlushM;
  logic [3:0]  BTBIClassF, InstrClassE;
  logic [31:0] PCLinkE, RASPCF;

  int n_checks = 0;
  int n_fail   = 0;

  ret_addr_stack #(.P(TB_CFG), .ENTRIES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushM      (FlushM),
    .BTBIClassF  (BTBIClassF),
    .InstrClassE (InstrClassE),
    .PCLinkE     (PCLinkE),
    .RASPCF      (RASPCF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sf, se, fd, fm;
    logic [3:0]  btbi, ice;
    logic [31:0] link;
    logic [31:0] exp_ras;
    logic [3:0]  exp_spec, exp_commit;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic sf, logic se, logic fd, logic fm,
                              logic [3:0] btbi, logic [3:0] ice, logic [31:0] link,
                              logic [31:0] exp_ras, logic [3:0] es, logic [3:0] ec);
    vec_t v;
    v.rst = rst; v.sf = sf; v.se = se; v.fd = fd; v.fm = fm;
    v.btbi = btbi; v.ice = ice; v.link = link;
    v.exp_ras = exp_ras; v.exp_spec = es; v.exp_commit = ec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 ns later.
  task automatic apply(string tag, vec_t v);
    reset = v.rst; StallF = v.sf; StallE = v.se; FlushD = v.fd; FlushM = v.fm;
    BTBIClassF = v.btbi; InstrClassE = v.ice; PCLinkE = v.link;
    @(posedge clk);
    #1;
    check({tag, " ras"},    RASPCF,                   v.exp_ras);
    check({tag, " spec"},   32'(dut.spec_ptr),        32'(v.exp_spec));
    check({tag, " commit"}, 32'(dut.commit_ptr),      32'(v.exp_commit));
  endtask

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] RET  = 4'b0100;
  localparam logic [3:0] CAL  = 4'b1000;
  localparam logic [3:0] CR   = 4'b1100;

  initial begin
    reset = 1'b0; StallF = 1'b0; StallE = 1'b0; FlushD = 1'b0; FlushM = 1'b0;
    BTBIClassF = '0; InstrClassE = '0; PCLinkE = '0;

    //           rst sf se fd fm btbi  ice   link        exp_ras     spec commit
    tbl.push_back(mk(0, 0, 0, 0, 0, NONE, NONE, 32'h0,     32'h0,      0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, NONE, NONE, 32'h0,     32'h0,      0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, NONE, 32'h0,     32'h0,      0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, RET,  NONE, 32'h0,     32'h0,     15,  0));
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, NONE, 32'h0,     32'h0,      0,  0));
    // push/pop
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, CAL,  32'h1004,  32'h1004,   1,  1));
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, CAL,  32'h2008,  32'h2008,   2,  2));
    tbl.push_back(mk(1, 0, 0, 0, 0, RET,  NONE, 32'h0,     32'h1004,   1,  2));
    tbl.push_back(mk(1, 0, 0, 0, 0, RET,  NONE, 32'h0,     32'h0,      0,  2));
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, NONE, 32'h0,     32'h2008,   2,  2));
    // misprediction restore
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, CAL,  32'hA0,    32'hA0,     3,  3));
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, CAL,  32'hB0,    32'hB0,     4,  4));
    tbl.push_back(mk(1, 0, 0, 0, 0, RET,  NONE, 32'h0,     32'hA0,     3,  4));
    tbl.push_back(mk(1, 0, 0, 0, 0, RET,  NONE, 32'h0,     32'h2008,   2,  4));
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, NONE, 32'h0,     32'hB0,     4,  4));
    // simultaneous pop + push, then restore
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, CAL,  32'h500,   32'h500,    5,  5));
    tbl.push_back(mk(1, 0, 0, 0, 0, RET,  CAL,  32'h600,   32'h500,    5,  6));
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, NONE, 32'h0,     32'h600,    6,  6));
    // flush + push in the same cycle
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, CAL,  32'h700,   32'h700,    7,  7));
    // stall/flush gating
    tbl.push_back(mk(1, 1, 0, 0, 0, RET,  NONE, 32'h0,     32'h700,    7,  7));
    tbl.push_back(mk(1, 0, 0, 0, 1, NONE, CAL,  32'hDEAD,  32'h700,    7,  7));
    tbl.push_back(mk(1, 0, 1, 0, 0, NONE, CAL,  32'hBEEF,  32'h700,    7,  7));
    tbl.push_back(mk(1, 0, 0, 0, 0, RET,  NONE, 32'h0,     32'h600,    6,  7));
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, NONE, 32'h0,     32'h700,    7,  7));
    // coroutine: overwrites committed top; spec moves up onto untouched entry 8
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, CR,   32'h7A0,   32'h0,      8,  7));
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, NONE, 32'h0,     32'h7A0,    7,  7));
    // committed return alone
    tbl.push_back(mk(1, 0, 0, 0, 0, NONE, RET,  32'h0,     32'h7A0,    7,  6));
    tbl.push_back(mk(1, 0, 0, 1, 0, NONE, NONE, 32'h0,     32'h600,    6,  6));
    // reset overrides everything
    tbl.push_back(mk(0, 0, 0, 1, 0, RET,  CAL,  32'h999,   32'h0,      0,  0));

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    // Overflow: 17 committed calls from an empty stack.
    for (int i = 0; i < 17; i++) begin
      logic [3:0] p;
      p = 4'((i + 1) % 16);
      apply($sformatf("ovf_push%0d", i),
            mk(1, 0, 0, 0, 0, NONE, CAL, 32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), p, p));
    end
    // 16 pops: 0x13C down to 0x104, then the wrapped 0x140.
    for (int k = 1; k <= 16; k++) begin
      logic [3:0]  j;
      logic [31:0] e;
      j = 4'((17 - k) % 16);
      e = (j == 4'd1) ? 32'h140 : 32'h100 + 32'(4 * ((int'(j) + 15) % 16));
      apply($sformatf("ovf_pop%0d", k), mk(1, 0, 0, 0, 0, RET, NONE, 32'h0, e, j, 4'd1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
